// File: rtl/ram_scan_display_if.sv
// rtl/ram_scan_display_if.sv - control/readback bus between board controls and ram_scan_display
// Signals:
//   address  manual-mode address           (master -> slave)
//   data     write data                    (master -> slave)
//   wren     write enable, manual mode     (master -> slave)
//   scan_en  1 = scan mode, 0 = manual     (master -> slave)
//   q        registered read data          (slave -> master)
//   busy     high while memory clear runs  (slave -> master)
interface ram_scan_display_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              scan_en;
  logic [DATA_W-1:0] q;
  logic              busy;

  modport master (output address, data, wren, scan_en, input q, busy);
  modport slave  (input address, data, wren, scan_en, output q, busy);
endinterface

// File: rtl/ram_scan_display.sv
// rtl/ram_scan_display.sv - DATA_W x 2**ADDR_W RAM with clear sequencer, auto-scan and hex readout
// Ports:
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   bus        slave side of ram_scan_display_if (address/data/wren/scan_en in, q/busy out)
//   H5_addr_1  effective address, high nibble (segments a..g, active-low)
//   H4_addr_0  effective address, low nibble
//   H3_data_1  write data, high nibble
//   H2_data_0  write data, low nibble
//   H1_q_1     read data q, high nibble
//   H0_q_0     read data q, low nibble
module ram_scan_display #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 25000000
) (
  input  logic              clk,
  input  logic              resetn,
  ram_scan_display_if.slave bus,
  output logic [0:6]        H5_addr_1,
  output logic [0:6]        H4_addr_0,
  output logic [0:6]        H3_data_1,
  output logic [0:6]        H2_data_0,
  output logic [0:6]        H1_q_1,
  output logic [0:6]        H0_q_0
);
  localparam int DEPTH = 2 ** ADDR_W;
  // A divider of 1 still needs a one-bit counter that simply sits at 0.
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR,
    MANUAL,
    SCAN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] scan_addr;
  logic [DIV_W-1:0]  div_cnt;
  logic [DATA_W-1:0] q_r;
  logic              busy_r;
  logic [ADDR_W-1:0] eff_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    eff_addr = bus.address;
    case (state)
      CLEAR:   eff_addr = clr_addr;
      SCAN:    eff_addr = scan_addr;
      default: eff_addr = bus.address;
    endcase
  end

  // Control FSM plus the read register. The read uses the pre-edge contents,
  // so a same-cycle write to the same address returns the old word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      scan_addr <= '0;
      div_cnt   <= '0;
      q_r       <= '0;
      busy_r    <= 1'b1;
    end else begin
      q_r <= mem[eff_addr];
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_LAST) begin
            busy_r <= 1'b0;
            state  <= bus.scan_en ? SCAN : MANUAL;
          end
        end
        MANUAL: begin
          if (bus.scan_en) begin
            state     <= SCAN;
            scan_addr <= bus.address;
            div_cnt   <= '0;
          end
        end
        SCAN: begin
          if (!bus.scan_en) state <= MANUAL;
          // Address width equals log2(DEPTH), so the increment wraps by itself.
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            scan_addr <= scan_addr + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset of its own; the CLEAR pass zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (state == MANUAL && bus.wren) begin
        mem[bus.address] <= bus.data;
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;

  function automatic logic [0:6] seg7(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Narrow values are zero-extended to a full byte before nibble split.
  logic [7:0] addr8;
  logic [7:0] data8;
  logic [7:0] q8;

  always_comb begin
    addr8 = '0;
    data8 = '0;
    q8    = '0;
    addr8[ADDR_W-1:0] = eff_addr;
    data8[DATA_W-1:0] = bus.data;
    q8[DATA_W-1:0]    = q_r;
  end

  assign H5_addr_1 = seg7(addr8[7:4]);
  assign H4_addr_0 = seg7(addr8[3:0]);
  assign H3_data_1 = seg7(data8[7:4]);
  assign H2_data_0 = seg7(data8[3:0]);
  assign H1_q_1    = seg7(q8[7:4]);
  assign H0_q_0    = seg7(q8[3:0]);
endmodule

// File: tb/tb_ram_scan_display.sv
// tb/tb_ram_scan_display.sv - self-checking bench for ram_scan_display
module tb_ram_scan_display;
  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 5;
  localparam int SCAN_DIV = 4;
  localparam int DEPTH    = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ram_scan_display_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic [0:6] h5, h4, h3, h2, h1, h0;

  ram_scan_display #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .H5_addr_1 (h5),
    .H4_addr_0 (h4),
    .H3_data_1 (h3),
    .H2_data_0 (h2),
    .H1_q_1    (h1),
    .H0_q_0    (h0)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = clearing, 1 = manual, 2 = scanning.
  int mem_m [DEPTH];
  int mode;
  int clr_idx;
  int scan_base;
  int scan_ticks;
  int q_m;
  bit q_known;
  bit busy_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v & 15)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [13:0] pair(input int v);
    return {glyph(v >> 4), glyph(v & 15)};
  endfunction

  // Location currently shown/read: scan position is start plus elapsed steps.
  function automatic int exp_addr();
    case (mode)
      0:       return clr_idx;
      2:       return (scan_base + scan_ticks / SCAN_DIV) % DEPTH;
      default: return int'(bus.address);
    endcase
  endfunction

  task automatic cycle(input bit rn, input int a, input int d, input int w, input int s);
    int ra;
    resetn      = rn;
    bus.address = ADDR_W'(a);
    bus.data    = DATA_W'(d);
    bus.wren    = w[0];
    bus.scan_en = s[0];
    ra = exp_addr();
    @(posedge clk);
    #1;
    if (!rn) begin
      mode = 0; clr_idx = 0; scan_base = 0; scan_ticks = 0;
      q_m = 0; q_known = 1; busy_m = 1;
    end else begin
      case (mode)
        0: begin
          mem_m[clr_idx] = 0;
          clr_idx++;
          q_known = 0;
          if (clr_idx == DEPTH) begin
            clr_idx = 0;
            busy_m  = 0;
            mode    = s ? 2 : 1;
          end
        end
        1: begin
          q_m = mem_m[a];
          q_known = 1;
          if (w != 0) mem_m[a] = d;
          if (s != 0) begin
            mode = 2; scan_base = a; scan_ticks = 0;
          end
        end
        default: begin
          q_m = mem_m[ra];
          q_known = 1;
          scan_ticks++;
          if (s == 0) mode = 1;
        end
      endcase
    end
    chk("busy", 32'(bus.busy), 32'(busy_m));
    chk("hex_addr", 32'({h5, h4}), 32'(pair(exp_addr())));
    chk("hex_data", 32'({h3, h2}), 32'(pair(d)));
    if (q_known) begin
      chk("q", 32'(bus.q), 32'(q_m));
      chk("hex_q", 32'({h1, h0}), 32'(pair(q_m)));
    end
  endtask

  task automatic clear_run(input string tag);
    int n;
    n = 0;
    do begin
      cycle(1, $urandom_range(DEPTH - 1), $urandom_range(15), $urandom_range(1), 0);
      n++;
    end while (bus.busy === 1'b1 && n < 100);
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    resetn = 1'b0;
    bus.address = '0; bus.data = '0; bus.wren = 1'b0; bus.scan_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    mode = 0; clr_idx = 0; scan_base = 0; scan_ticks = 0; q_m = 0; q_known = 0; busy_m = 1;

    // Reset state
    cycle(0, 0, 3, 0, 0);
    cycle(0, 0, 12, 0, 0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_q", 32'(bus.q), 32'd0);
    chk("rst_h5h4", 32'({h5, h4}), 32'({7'b0000001, 7'b0000001}));
    clear_run("busy_len_initial");

    // Random manual traffic preloads non-zero contents
    for (int i = 0; i < 60; i++)
      cycle(1, $urandom_range(DEPTH - 1), $urandom_range(1, 15), $urandom_range(1), 0);

    // Reset then full clear; every location must read zero
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    clear_run("busy_len_after_preload");
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, i, $urandom_range(15), 0, 0);
      chk("clr_zero", 32'(bus.q), 32'd0);
    end

    // Manual write/read at 0x13
    cycle(1, 'h13, 'hA, 1, 0);
    cycle(1, 'h13, 'hA, 0, 0);
    chk("man_q", 32'(bus.q), 32'hA);
    chk("man_h5", 32'(h5), 32'(7'b1001111));
    chk("man_h4", 32'(h4), 32'(7'b0000110));
    chk("man_h0", 32'(h0), 32'(7'b0001000));
    chk("man_h1", 32'(h1), 32'(7'b0000001));

    // Read-before-write
    cycle(1, 7, 3, 1, 0);
    cycle(1, 7, 5, 1, 0);
    chk("rbw_old", 32'(bus.q), 32'd3);
    cycle(1, 7, 5, 0, 0);
    chk("rbw_new", 32'(bus.q), 32'd5);

    // Scan from 30 with wrap; wren/data must be ignored
    cycle(1, 30, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cycle(1, 30, 15, 1, 1);
      if (i < 9) chk("scan_wrap", 32'({h5, h4}), 32'(pair(i < 4 ? 30 : (i < 8 ? 31 : 0))));
    end
    chk("scan_at2", 32'({h5, h4}), 32'(pair(2)));

    // Mode return: scan position 2, manual address 9
    cycle(1, 9, 6, 1, 0);
    chk("ret_addr", 32'({h5, h4}), 32'(pair(9)));
    cycle(1, 9, 6, 1, 0);
    cycle(1, 9, 6, 0, 0);
    chk("ret_write", 32'(bus.q), 32'd6);
    for (int i = 28; i < 36; i++) begin
      cycle(1, i % DEPTH, 0, 0, 0);
      chk("scan_nowrite", 32'(bus.q), 32'(mem_m[i % DEPTH]));
    end

    // Reset mid-scan, then again at clear cycle 10
    for (int i = 0; i < 12; i++) cycle(1, 4, $urandom_range(1, 15), 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 4, 0, 0, 1);
    cycle(0, 4, 0, 0, 1);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 0);
    chk("mid_clr10", 32'({h5, h4}), 32'(pair(10)));
    cycle(0, 0, 0, 0, 0);
    chk("mid_restart", 32'({h5, h4}), 32'(pair(0)));
    clear_run("busy_len_mid");
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1, i, 0, 0, 0);
      chk("mid_zero", 32'(bus.q), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_scan_display.md
Name: ram_scan_display

Overview:
- Parametrised successor to the 32x4 in-memory RAM with hex readout: generic DATA_W x 2**ADDR_W synchronous RAM with board-level seven-segment readout of address, write data and read data.
- Adds a post-reset memory-clear sequencer and an auto-scan mode that steps through all locations at a programmable rate.
- Sits directly behind board switches, keys and HEX displays as a lab-level top or sub-top.

Parameters:
- DATA_W, 4, data word width; legal range 1..8.
- ADDR_W, 5, address width; legal range 1..8; DEPTH = 2**ADDR_W.
- SCAN_DIV, 25000000, clock cycles per scan step; minimum 1 (0.5 s at 50 MHz).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- address  in  ADDR_W  manual-mode address.
- data  in  DATA_W  write data.
- wren  in  1  write enable; manual mode only.
- scan_en  in  1  1 = scan mode, 0 = manual mode.
- q  out  DATA_W  registered read data.
- busy  out  1  high while clear is in progress.
- H5_addr_1, H4_addr_0  out  [0:6] each  address, high and low nibble.
- H3_data_1, H2_data_0  out  [0:6] each  data input, high and low nibble.
- H1_q_1, H0_q_0  out  [0:6] each  q, high and low nibble.

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are named clk and resetn.
- Segment encoding:
  - Index 0..6 = segments a..g, active-low.
  - Hex 0..F uses the standard glyphs, e.g. "0" = 0000001, "A" = 0001000.
  - Values narrower than 8 bits are zero-extended before splitting into nibbles.
- FSM states: CLEAR, MANUAL, SCAN.
- Reset:
  - resetn low at a clock edge -> state CLEAR, clr_addr = 0, scan_addr = 0, div_cnt = 0, q = 0, busy = 1.
  - Reset is honoured from any state, including mid-clear and mid-scan.
- CLEAR:
  - Each cycle writes 0 to mem[clr_addr], then clr_addr increments.
  - After the write at DEPTH-1: busy drops to 0 on the next edge; the next state is SCAN if scan_en = 1, else MANUAL.
  - busy is high for exactly DEPTH cycles after reset release.
  - wren, data and address are ignored during CLEAR.
- Effective address:
  - eff_addr = clr_addr in CLEAR, address in MANUAL, scan_addr in SCAN.
  - H5/H4 always display eff_addr (combinational).
- MANUAL:
  - wren = 1 writes data to mem[address] at the edge.
  - scan_en = 1 -> SCAN at the next edge; scan_addr loads address and div_cnt clears.
- SCAN:
  - div_cnt counts 0..SCAN_DIV-1.
  - On the terminal count, scan_addr increments, wrapping from DEPTH-1 to 0, and div_cnt returns to 0.
  - wren is ignored.
  - scan_en = 0 -> MANUAL at the next edge.
- Read path:
  - q <= mem[eff_addr] every edge; one-cycle latency.
  - A write and read to the same address in the same cycle returns the old data (read-before-write). The new data appears on the following cycle.
  - During CLEAR, q follows the clear sequence, i.e. reads 0 or stale contents; this is don't-care for checking.
- H3/H2 decode data combinationally in every state. H1/H0 decode q.
- Reset values:
  - q = 0, so H1/H0 = "0".
  - busy = 1.
  - H5/H4 = "0", since clr_addr = 0.
  - H3/H2 follow data.
- No X on any output after the first reset edge.

Test Plan:
(ADDR_W = 5, DATA_W = 4, SCAN_DIV = 4 unless stated.)
- Reset/clear:
  - Stimulus: preload mem with non-zero values via manual writes, resetn low 2 cycles, release, scan_en = 0.
  - Required: busy = 1 for exactly 32 cycles then 0; reading all 32 addresses gives q = 0.
- Manual write/read:
  - Stimulus: address = 5'h13, data = 4'hA, wren = 1 for one cycle; then wren = 0.
  - Required: q = 4'hA one cycle later; H5 = "1" (1001111), H4 = "3" (0000110), H0 = "A" (0001000), H1 = "0".
- Read-before-write:
  - Stimulus: mem[7] = 3; address = 7, data = 5, wren = 1.
  - Required: q = 3 after that edge, q = 5 after the next.
- Scan with wrap:
  - Stimulus: address = 30, scan_en 0 -> 1, wren = 1 with data = F.
  - Required: eff_addr = 30 for 4 cycles, then 31 for 4, then 0; no location is written.
- Mode return:
  - Stimulus: scan_en 1 -> 0 while scan_addr = 2, address = 9.
  - Required: eff_addr = 9 at the next edge; wren takes effect again.
- Reset mid-operation:
  - Stimulus: assert resetn low during SCAN and again at clear cycle 10.
  - Required: busy re-asserts, clr_addr restarts at 0, and the full 32-cycle clear completes with all locations = 0.
